psum_sram_responder: RTL and testbench

Single-port partial-sum SRAM that answers the packed 141-bit memory request bus driven by the special-function unit (SFU). Each cycle it decodes one request word, performs the read or write against a DEPTH x 128-bit array, and returns read data one cycle later on the 128-bit response bus. It also provides a hardware clear sweep, sticky error reporting and access counters for debug.

---
 rtl/psum_sram_responder_if.sv | 19 +
 rtl/psum_sram_responder.sv | 142 ++++++++++++++
 tb/tb_psum_sram_responder.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/psum_sram_responder_if.sv
// ---------------------------------------------------------------------------
// psum_sram_responder_if
// Request/response bundle between the SFU and the partial-sum SRAM.
//   mem_in  : packed request word {cen_n, wen_n, addr[ADDR_W-1:0], wdata[DATA_W-1:0]}
//   mem_out : registered read data returned one cycle after a read request
// Modports: master (SFU side), slave (SRAM side).
// ---------------------------------------------------------------------------
interface psum_sram_responder_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 128
);
    localparam int REQ_W = DATA_W + ADDR_W + 2;

    logic [REQ_W-1:0]  mem_in;
    logic [DATA_W-1:0] mem_out;

    modport master (output mem_in, input mem_out);
    modport slave  (input mem_in, output mem_out);
endinterface

// File: rtl/psum_sram_responder.sv
// ---------------------------------------------------------------------------
// psum_sram_responder
// Single-port DEPTH x DATA_W partial-sum SRAM serving the SFU request bus.
// One request per cycle; read data appears on mem_out one cycle later.
// A clear pulse launches a zeroing sweep of the whole array (busy high).
// Ports:
//   clk, reset     : clock, asynchronous active-high reset
//   mem (slave)    : mem_in request word, mem_out registered read data
//   clear          : one-cycle pulse starting the clear sweep
//   busy           : high while the sweep runs
//   err            : sticky error (out-of-range access or access while busy)
//   rd_cnt, wr_cnt : saturating counts of accepted reads / writes
// ---------------------------------------------------------------------------
module psum_sram_responder #(
    parameter int DEPTH  = 160,
    parameter int ADDR_W = 11,
    parameter int DATA_W = 128,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    psum_sram_responder_if.slave mem,
    input  logic                 clear,
    output logic                 busy,
    output logic                 err,
    output logic [CNT_W-1:0]     rd_cnt,
    output logic [CNT_W-1:0]     wr_cnt
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);
    localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(DEPTH - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   clr_ptr_q, clr_ptr_d;
    logic [DATA_W-1:0]  mem_out_q, mem_out_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0]   wr_cnt_q, wr_cnt_d;

    logic [DATA_W-1:0]  arr_q [DEPTH];
    logic               arr_we;
    logic [PTR_W-1:0]   arr_waddr;
    logic [DATA_W-1:0]  arr_wdata;

    // Request word fields
    logic               req_cen_n;
    logic               req_wen_n;
    logic [ADDR_W-1:0]  req_addr;
    logic [DATA_W-1:0]  req_data;
    logic               in_range;
    logic [PTR_W-1:0]   addr_idx;

    assign req_cen_n = mem.mem_in[DATA_W+ADDR_W+1];
    assign req_wen_n = mem.mem_in[DATA_W+ADDR_W];
    assign req_addr  = mem.mem_in[DATA_W+ADDR_W-1:DATA_W];
    assign req_data  = mem.mem_in[DATA_W-1:0];
    assign in_range  = (req_addr < DEPTH_A);
    // Only meaningful when in_range; the upper address bits are then zero.
    assign addr_idx  = req_addr[PTR_W-1:0];

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        mem_out_d = mem_out_q;
        err_d     = err_q;
        rd_cnt_d  = rd_cnt_q;
        wr_cnt_d  = wr_cnt_q;
        arr_we    = 1'b0;
        arr_waddr = addr_idx;
        arr_wdata = req_data;

        case (state_q)
            IDLE: begin
                // The request in the clear cycle is still served.
                if (!req_cen_n) begin
                    if (in_range) begin
                        if (req_wen_n) begin
                            mem_out_d = arr_q[addr_idx];
                            rd_cnt_d  = sat_inc(rd_cnt_q);
                        end else begin
                            arr_we   = 1'b1;
                            wr_cnt_d = sat_inc(wr_cnt_q);
                        end
                    end else begin
                        err_d = 1'b1;
                        if (req_wen_n) mem_out_d = '0;
                    end
                end
                if (clear) state_d = CLEAR;
            end
            CLEAR: begin
                // Port is owned by the sweep; any request is refused.
                arr_we    = 1'b1;
                arr_waddr = clr_ptr_q;
                arr_wdata = '0;
                if (!req_cen_n) err_d = 1'b1;
                if (clr_ptr_q == LAST_PTR) begin
                    state_d   = IDLE;
                    clr_ptr_d = '0;
                end else begin
                    clr_ptr_d = clr_ptr_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            clr_ptr_q <= '0;
            mem_out_q <= '0;
            err_q     <= 1'b0;
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            mem_out_q <= mem_out_d;
            err_q     <= err_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
        end
    end

    // Storage array carries no reset; contents are defined by a clear sweep.
    always_ff @(posedge clk) begin
        if (arr_we) arr_q[arr_waddr] <= arr_wdata;
    end

    assign mem.mem_out = mem_out_q;
    assign busy        = (state_q == CLEAR);
    assign err         = err_q;
    assign rd_cnt      = rd_cnt_q;
    assign wr_cnt      = wr_cnt_q;
endmodule

// File: tb/tb_psum_sram_responder.sv
module tb_psum_sram_responder;
    localparam int DEPTH  = 160;
    localparam int ADDR_W = 11;
    localparam int DATA_W = 128;
    localparam int CNT_W  = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             clear;
    logic             busy;
    logic             err;
    logic [CNT_W-1:0] rd_cnt;
    logic [CNT_W-1:0] wr_cnt;

    int checks   = 0;
    int failures = 0;

    psum_sram_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_if ();

    psum_sram_responder #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .mem(mem_if.slave),
        .clear(clear),
        .busy(busy),
        .err(err),
        .rd_cnt(rd_cnt),
        .wr_cnt(wr_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DATA_W-1:0] got,
                       input logic [DATA_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DATA_W+ADDR_W+1:0] req(input logic cen_n, input logic wen_n,
                                                     input int addr,
                                                     input logic [DATA_W-1:0] d);
        return {cen_n, wen_n, ADDR_W'(addr), d};
    endfunction

    function automatic logic [DATA_W-1:0] lane_pat(input int a);
        return {8{16'(a)}};
    endfunction

    task automatic idle_req();
        mem_if.mem_in = req(1'b1, 1'b1, 0, '0);
    endtask

    task automatic do_write(input int addr, input logic [DATA_W-1:0] d);
        mem_if.mem_in = req(1'b0, 1'b0, addr, d);
        tick();
        idle_req();
    endtask

    task automatic do_read(input int addr);
        mem_if.mem_in = req(1'b0, 1'b1, addr, '0);
        tick();
        idle_req();
    endtask

    // Pulse clear and count edges until busy falls (160 expected).
    task automatic clear_sweep(input string tag);
        int k;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk({tag, "_busy_up"}, DATA_W'(busy), DATA_W'(1));
        k = 0;
        while (busy && k < 300) begin
            tick();
            k++;
        end
        chk({tag, "_len"}, DATA_W'(k), DATA_W'(DEPTH));
    endtask

    initial begin
        logic [DATA_W-1:0] w5;
        int k;
        int a;
        w5 = 128'h0001_0002_0003_0004_0005_0006_0007_0008;
        reset = 1'b1;
        clear = 1'b0;
        idle_req();
        tick();
        tick();
        chk("rst_mem_out", mem_if.mem_out, '0);
        chk("rst_busy",    DATA_W'(busy),   '0);
        chk("rst_err",     DATA_W'(err),    '0);
        chk("rst_rd_cnt",  DATA_W'(rd_cnt), '0);
        chk("rst_wr_cnt",  DATA_W'(wr_cnt), '0);
        reset = 1'b0;
        tick();

        // Clear, then read back zeros.
        clear_sweep("clr1");
        do_read(0);   chk("rd0",   mem_if.mem_out, '0);
        do_read(80);  chk("rd80",  mem_if.mem_out, '0);
        do_read(159); chk("rd159", mem_if.mem_out, '0);
        chk("clr1_rd_cnt", DATA_W'(rd_cnt), DATA_W'(3));
        chk("clr1_err",    DATA_W'(err),    '0);

        // Write then read next cycle; no write-through.
        do_write(5, w5);
        chk("wr_no_thru", mem_if.mem_out, '0);
        do_read(5);
        chk("wr_rd5",   mem_if.mem_out, w5);
        chk("wr_cnt1",  DATA_W'(wr_cnt), DATA_W'(1));
        chk("rd_cnt4",  DATA_W'(rd_cnt), DATA_W'(4));

        // Fill addresses 16..159 with lane = address.
        for (int i = 16; i < DEPTH; i++) begin
            mem_if.mem_in = req(1'b0, 1'b0, i, lane_pat(i));
            tick();
        end
        idle_req();
        // Back-to-back reads stepping down by 16; data 1 cycle later.
        a = 159;
        while (a >= 0) begin
            mem_if.mem_in = req(1'b0, 1'b1, a, '0);
            tick();
            chk($sformatf("acc_rd%0d", a), mem_if.mem_out, (a >= 16) ? lane_pat(a) : '0);
            a -= 16;
        end
        idle_req();
        chk("acc_wr_cnt", DATA_W'(wr_cnt), DATA_W'(145));
        chk("acc_rd_cnt", DATA_W'(rd_cnt), DATA_W'(14));
        chk("acc_rd5",    mem_if.mem_out, '0);

        // Out-of-range write and read.
        do_read(159);
        chk("oor_pre", mem_if.mem_out, lane_pat(159));
        do_write(200, {8{16'hBEEF}});
        chk("oor_wr_err",   DATA_W'(err),    DATA_W'(1));
        chk("oor_wr_cnt",   DATA_W'(wr_cnt), DATA_W'(145));
        chk("oor_wr_hold",  mem_if.mem_out,  lane_pat(159));
        do_read(200);
        chk("oor_rd_zero",  mem_if.mem_out,  '0);
        chk("oor_rd_cnt",   DATA_W'(rd_cnt), DATA_W'(15));
        do_read(31);
        chk("oor_valid_rd", mem_if.mem_out,  lane_pat(31));
        do_write(40, lane_pat(41));
        chk("oor_err_stay", DATA_W'(err),    DATA_W'(1));
        do_read(40);
        chk("oor_rd40",     mem_if.mem_out,  lane_pat(41));

        // Fresh reset, then requests during a sweep are refused.
        reset = 1'b1;
        tick();
        chk("rst2_err",    DATA_W'(err),    '0);
        chk("rst2_rd_cnt", DATA_W'(rd_cnt), '0);
        reset = 1'b0;
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        k = 0;
        while (busy && k < 300) begin
            if (k == 9)       mem_if.mem_in = req(1'b0, 1'b0, 5, w5);
            else if (k == 10) mem_if.mem_in = req(1'b0, 1'b1, 100, '0);
            else              idle_req();
            tick();
            k++;
        end
        idle_req();
        chk("busy_req_len",  DATA_W'(k),      DATA_W'(DEPTH));
        chk("busy_req_err",  DATA_W'(err),    DATA_W'(1));
        chk("busy_req_wr",   DATA_W'(wr_cnt), '0);
        chk("busy_req_rd",   DATA_W'(rd_cnt), '0);
        chk("busy_req_mout", mem_if.mem_out,  '0);
        do_read(5);
        chk("busy_req_a5",   mem_if.mem_out,  '0);

        // Asynchronous reset mid-sweep.
        do_write(7, lane_pat(7));
        do_read(7);
        chk("ar_pre", mem_if.mem_out, lane_pat(7));
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int i = 0; i < 49; i++) tick();
        chk("ar_busy_mid", DATA_W'(busy), DATA_W'(1));
        #2 reset = 1'b1;
        #1;
        chk("ar_busy", DATA_W'(busy),   '0);
        chk("ar_mout", mem_if.mem_out,  '0);
        chk("ar_wr",   DATA_W'(wr_cnt), '0);
        tick();
        reset = 1'b0;
        tick();
        clear_sweep("clr2");
        do_read(7);
        chk("clr2_rd7", mem_if.mem_out, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
